hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-sequencing controller for the aww pipelined core. It sits beside the datapath and takes register/opcode hints from the latches plus the cache hit/request handshakes. From those it drives per-latch stall and flush vectors, the PC write enable, and a sticky halt. It adds a load-latency bubble counter, a halt-drain FSM, configurable depth and branch-resolve stage, and optional no-forwarding RAW interlock.

---
 rtl/aww_types_pkg.sv | 17 +
 rtl/hazard_detect.sv | 35 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aww_types_pkg.sv
// Shared types for the aww core pipeline control.
// Hazard FSM states and pipeline latch indices.
package aww_types_pkg;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    DRAIN,
    HALTED
  } hz_state_t;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

endpackage

// File: rtl/hazard_detect.sv
// Source/destination comparator for load-use and RAW hazards.
// HAZARD_FWD_EN: full forwarding, RAW interlock removed.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_load,
  input  logic             ex_wen,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_wen,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             ld_use,
  output logic             raw_hit
);

  logic ex_m;

  assign ex_m = (ex_rd != '0) &&
                ((ex_rd == id_rs) || (ex_rd == id_rt));

  assign ld_use = ex_load & ex_m;

`ifdef HAZARD_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_wen, mem_wen, mem_rd};
  assign raw_hit    = 1'b0;
`else
  logic mem_m;
  assign mem_m = (mem_rd != '0) &&
                 ((mem_rd == id_rs) || (mem_rd == id_rt));
  assign raw_hit = (ex_wen & ex_m) | (mem_wen & mem_m);
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-sequencing controller for the aww core.
// Optional macro HAZARD_FWD_EN disables the RAW interlock.
module hazard_ctrl
  import aww_types_pkg::*;
#(
  parameter int NLATCH   = 4,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 2,
  parameter int REG_W    = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_req,
  input  logic              ex_load,
  input  logic              ex_wen,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              mem_wen,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              br_taken,
  input  logic              halt_in,
  output logic [NLATCH-1:0] stall,
  output logic [NLATCH-1:0] flush,
  output logic              pc_wen,
  output logic              halt_out
);

  localparam int DW = $clog2(NLATCH + 1);

  hz_state_t st, st_n;
  logic [2:0]    bub, bub_n;
  logic [DW-1:0] drn, drn_n;
  logic          ld_use, raw_hit, mem_wait;

  hazard_detect #(.REG_W(REG_W)) u_det (
    .ex_load (ex_load),
    .ex_wen  (ex_wen),
    .ex_rd   (ex_rd),
    .mem_wen (mem_wen),
    .mem_rd  (mem_rd),
    .id_rs   (id_rs),
    .id_rt   (id_rt),
    .ld_use  (ld_use),
    .raw_hit (raw_hit)
  );

  assign mem_wait = mem_req & ~dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st       <= RUN;
      bub      <= '0;
      drn      <= '0;
      halt_out <= 1'b0;
    end else begin
      st       <= st_n;
      bub      <= bub_n;
      drn      <= drn_n;
      halt_out <= (st_n == HALTED);
    end
  end

  always_comb begin
    st_n   = st;
    bub_n  = bub;
    drn_n  = drn;
    stall  = '0;
    flush  = '0;
    pc_wen = 1'b0;
    if (!nRST) begin
      flush = '1;
    end else begin
      unique case (st)
        RUN, LDSTALL: begin
          if (mem_wait) begin
            stall[NLATCH-2:0] = '1;
            flush[NLATCH-1]   = 1'b1;
          end else if (st == RUN && halt_in) begin
            st_n        = DRAIN;
            drn_n       = DW'(NLATCH - 1);
            flush[IFID] = 1'b1;
          end else if (st == LDSTALL) begin
            stall[IFID] = 1'b1;
            flush[IDEX] = 1'b1;
            if (bub <= 3'd1) begin
              st_n  = RUN;
              bub_n = '0;
            end else begin
              bub_n = bub - 3'd1;
            end
          end else if (ld_use) begin
            stall[IFID] = 1'b1;
            flush[IDEX] = 1'b1;
            if (LOAD_LAT > 1) begin
              st_n  = LDSTALL;
              bub_n = 3'(LOAD_LAT - 1);
            end
          end else if (raw_hit) begin
            stall[IFID] = 1'b1;
            flush[IDEX] = 1'b1;
          end else if (br_taken) begin
            flush[BR_STAGE-1:0] = '1;
            pc_wen              = 1'b1;
          end else if (!ihit) begin
            flush[IFID] = 1'b1;
          end else begin
            pc_wen = 1'b1;
          end
        end
        DRAIN: begin
          if (mem_wait) begin
            stall[NLATCH-2:0] = '1;
            flush[NLATCH-1]   = 1'b1;
          end else begin
            flush[IFID] = 1'b1;
            if (drn <= DW'(1)) begin
              st_n  = HALTED;
              drn_n = '0;
            end else begin
              drn_n = drn - DW'(1);
            end
          end
        end
        default: begin
          stall = '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (NLATCH=4, LOAD_LAT=3, BR_STAGE=2).
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit RAW_ON = 1'b0;
`else
  localparam bit RAW_ON = 1'b1;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] fl;
    logic       pc;
    logic       ht;
  } exp_t;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       mreq;
    logic       ld;
    logic       ewen;
    logic [4:0] erd;
    logic       mwen;
    logic [4:0] mrd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       halt;
  } vec_t;

  typedef struct packed {
    vec_t v;
    exp_t e;
  } row_t;

  logic       CLK, nRST;
  logic       ihit, dhit, mem_req, ex_load, ex_wen, mem_wen;
  logic [4:0] ex_rd, mem_rd, id_rs, id_rt;
  logic       br_taken, halt_in;
  logic [3:0] stall, flush;
  logic       pc_wen, halt_out;

  int n_chk;
  int n_fail;
  exp_t sb[$];

  hazard_ctrl #(
    .NLATCH(4), .LOAD_LAT(3), .BR_STAGE(2), .REG_W(5)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .ex_load(ex_load), .ex_wen(ex_wen), .ex_rd(ex_rd),
    .mem_wen(mem_wen), .mem_rd(mem_rd),
    .id_rs(id_rs), .id_rt(id_rt),
    .br_taken(br_taken), .halt_in(halt_in),
    .stall(stall), .flush(flush),
    .pc_wen(pc_wen), .halt_out(halt_out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "timeout");
  end

  function automatic exp_t ex(logic [3:0] s, logic [3:0] f,
                              logic p, logic h);
    exp_t e;
    e.st = s; e.fl = f; e.pc = p; e.ht = h;
    return e;
  endfunction

  function automatic vec_t idle_v();
    vec_t v;
    v = '0;
    v.ihit = 1'b1;
    v.dhit = 1'b1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; mem_req = v.mreq;
    ex_load = v.ld; ex_wen = v.ewen; ex_rd = v.erd;
    mem_wen = v.mwen; mem_rd = v.mrd;
    id_rs = v.rs; id_rt = v.rt;
    br_taken = v.br; halt_in = v.halt;
  endtask

  task automatic check(input string nm);
    exp_t e, a;
    a = {stall, flush, pc_wen, halt_out};
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b pc_wen=%b halt=%b, want stall=%b flush=%b pc_wen=%b halt=%b",
                 nm, a.st, a.fl, a.pc, a.ht, e.st, e.fl, e.pc, e.ht);
      end
    end
  endtask

  task automatic step(input vec_t v, input exp_t e, input string nm);
    apply(v);
    sb.push_back(e);
    @(negedge CLK);
    check(nm);
    @(posedge CLK);
    #1;
  endtask

  localparam int NV = 13;
  row_t tab [NV];

  exp_t e_idle, e_rsp, e_mw, e_dr, e_hlt, e_rst, e_raw;
  vec_t v, v_ld, v_mw;

  initial begin
    e_idle = ex(4'b0000, 4'b0000, 1'b1, 1'b0);
    e_rsp  = ex(4'b0001, 4'b0010, 1'b0, 1'b0);
    e_mw   = ex(4'b0111, 4'b1000, 1'b0, 1'b0);
    e_dr   = ex(4'b0000, 4'b0001, 1'b0, 1'b0);
    e_hlt  = ex(4'b1111, 4'b0000, 1'b0, 1'b1);
    e_rst  = ex(4'b0000, 4'b1111, 1'b0, 1'b0);
    e_raw  = RAW_ON ? e_rsp : e_idle;

    for (int i = 0; i < NV; i++) tab[i].v = idle_v();
    tab[0].e = e_idle;
    tab[1].v.ihit = 1'b0;
    tab[1].e = e_dr;
    tab[2].v.br = 1'b1;
    tab[2].e = ex(4'b0000, 4'b0011, 1'b1, 1'b0);
    tab[3].v.mreq = 1'b1; tab[3].v.dhit = 1'b0;
    tab[3].e = e_mw;
    tab[4].v.mreq = 1'b1;
    tab[4].e = e_idle;
    tab[5].v.mwen = 1'b1; tab[5].v.mrd = 5'd7; tab[5].v.rt = 5'd7;
    tab[5].e = e_raw;
    tab[6].v.ewen = 1'b1; tab[6].v.erd = 5'd3; tab[6].v.rs = 5'd3;
    tab[6].e = e_raw;
    tab[7].v.ewen = 1'b1; tab[7].v.mwen = 1'b1;
    tab[7].e = e_idle;
    tab[8].v.ld = 1'b1;
    tab[8].e = e_idle;
    tab[9].v.ld = 1'b1; tab[9].v.erd = 5'd5;
    tab[9].v.rs = 5'd6; tab[9].v.rt = 5'd7;
    tab[9].e = e_idle;
    tab[10].v.br = 1'b1; tab[10].v.ihit = 1'b0;
    tab[10].e = ex(4'b0000, 4'b0011, 1'b1, 1'b0);
    tab[11].v.br = 1'b1; tab[11].v.mwen = 1'b1;
    tab[11].v.mrd = 5'd9; tab[11].v.rs = 5'd9;
    tab[11].e = RAW_ON ? e_rsp : ex(4'b0000, 4'b0011, 1'b1, 1'b0);
    tab[12].v.br = 1'b1; tab[12].v.mreq = 1'b1; tab[12].v.dhit = 1'b0;
    tab[12].e = e_mw;

    n_chk = 0;
    n_fail = 0;
    nRST = 1'b0;
    apply(idle_v());

    for (int i = 0; i < 3; i++) begin
      sb.push_back(e_rst);
      @(negedge CLK);
      check($sformatf("reset%0d", i));
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step(idle_v(), e_idle, "post_reset");

    for (int i = 0; i < NV; i++)
      step(tab[i].v, tab[i].e, $sformatf("vec%0d", i));

    // load-use: exactly three bubbles, hazard only visible on the first
    v_ld = idle_v();
    v_ld.ld = 1'b1; v_ld.erd = 5'd5; v_ld.rs = 5'd5;
    step(v_ld, e_rsp, "ld_b1");
    step(idle_v(), e_rsp, "ld_b2");
    step(idle_v(), e_rsp, "ld_b3");
    step(idle_v(), e_idle, "ld_done");

    // memory wait inside LDSTALL freezes the bubble counter
    v_mw = idle_v();
    v_mw.mreq = 1'b1; v_mw.dhit = 1'b0;
    step(v_ld, e_rsp, "ldw_b1");
    step(v_mw, e_mw, "ldw_wait");
    step(idle_v(), e_rsp, "ldw_b2");
    step(idle_v(), e_rsp, "ldw_b3");
    step(idle_v(), e_idle, "ldw_done");

    v_ld.erd = 5'd0; v_ld.rs = 5'd0;
    step(v_ld, e_idle, "ld_r0");

    // branch held under a memory wait flushes once the wait clears
    v = v_mw;
    v.br = 1'b1;
    step(v, e_mw, "brw1");
    step(v, e_mw, "brw2");
    v.dhit = 1'b1;
    step(v, ex(4'b0000, 4'b0011, 1'b1, 1'b0), "brw_go");
    step(idle_v(), e_idle, "brw_done");

    // halt pulse: three drain cycles, then sticky halt
    v = idle_v();
    v.halt = 1'b1;
    step(v, e_dr, "halt_pulse");
    for (int i = 0; i < 3; i++)
      step(idle_v(), e_dr, $sformatf("drain%0d", i));
    v = idle_v();
    v.br = 1'b1;
    step(v, e_hlt, "halted0");
    step(v_mw, e_hlt, "halted1");
    step(idle_v(), e_hlt, "halted2");

    nRST = 1'b0;
    #1;
    sb.push_back(e_rst);
    check("rst_halted");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step(idle_v(), e_idle, "run_again");

    // halt wins over branch; wait freezes drain; reset mid-drain
    v = idle_v();
    v.halt = 1'b1; v.br = 1'b1;
    step(v, e_dr, "halt_br");
    step(idle_v(), e_dr, "d2_0");
    step(v_mw, e_mw, "d2_wait");
    step(idle_v(), e_dr, "d2_1");
    step(idle_v(), e_dr, "d2_2");
    nRST = 1'b0;
    #1;
    sb.push_back(e_rst);
    check("rst_drain");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step(idle_v(), e_idle, "run_final");
    step(idle_v(), e_idle, "no_halt");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
